// File: rtl/iob_eth_mdio_ctrl.sv
// ---------------------------------------------------------------------------
// iob_eth_mdio_ctrl
//
// MII management (MDIO/MDC) master. Serialises IEEE 802.3 clause-22 read and
// write frames towards an external PHY. The frame is optionally preceded by
// 32 preamble ones.
//
// Ports
//   clk_i        system clock
//   arst_n_i     asynchronous active-low reset
//   cke_i        clock enable; all state and outputs hold while low
//   clkdiv_i     MDC half-period in clk_i cycles (0 and 1 behave as 2)
//   no_pre_i     1 = skip the 32-bit preamble
//   cmd_valid_i  command request
//   cmd_read_i   1 = read, 0 = write
//   cmd_ready_o  controller idle; command taken this cycle when valid
//   phy_addr_i   PHY address
//   reg_addr_i   PHY register address
//   wdata_i      write data
//   busy_o       transaction in progress
//   done_o       one-cycle completion pulse
//   rdata_o      data of the last completed read
//   rd_err_o     last read saw no turnaround zero from the PHY
//   mdc_o        management clock
//   mdio_o       MDIO output value
//   mdio_oe_o    MDIO output enable (1 = drive)
//   mdio_i       MDIO input from pad
// ---------------------------------------------------------------------------
module iob_eth_mdio_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  input  logic             no_pre_i,
  input  logic             cmd_valid_i,
  input  logic             cmd_read_i,
  output logic             cmd_ready_o,
  input  logic [4:0]       phy_addr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [15:0]      wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      rdata_o,
  output logic             rd_err_o,
  output logic             mdc_o,
  output logic             mdio_o,
  output logic             mdio_oe_o,
  input  logic             mdio_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] r_half;
  // Bits remaining after the current one; the frame occupies values 31..0,
  // the preamble 63..32.
  logic [5:0]       r_bit_cnt;
  // Frame bits still to be put on the wire, MSB next.
  logic [31:0]      r_tx;
  logic [15:0]      r_rx;
  logic             r_ta_bit;
  logic             r_read;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_rdata;
  logic             r_rd_err;
  logic             r_mdc;
  logic             r_mdio;
  logic             r_oe;

  logic             w_accept;
  logic [DIV_W-1:0] w_half;
  logic [31:0]      w_frame;
  logic             w_phase_end;
  logic [5:0]       w_bit_next;

  assign w_accept    = cmd_valid_i & r_ready;
  assign w_half      = (clkdiv_i < DIV_W'(2)) ? DIV_W'(2) : clkdiv_i;
  // ST | OP | PHYAD | REGAD | TA | DATA. For reads the TA and DATA slots are
  // never driven, so their contents do not matter.
  assign w_frame     = {2'b01,
                        cmd_read_i ? 2'b10 : 2'b01,
                        phy_addr_i,
                        reg_addr_i,
                        cmd_read_i ? 2'b11 : 2'b10,
                        cmd_read_i ? 16'hFFFF : wdata_i};
  assign w_phase_end = (r_div_cnt == (r_half - DIV_W'(1)));
  assign w_bit_next  = r_bit_cnt - 6'd1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_half    <= DIV_W'(2);
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_ta_bit  <= 1'b0;
      r_read    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_rd_err  <= 1'b0;
      r_mdc     <= 1'b0;
      r_mdio    <= 1'b1;
      r_oe      <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_read    <= cmd_read_i;
            r_half    <= w_half;
            r_div_cnt <= '0;
            r_mdc     <= 1'b0;
            r_oe      <= 1'b1;
            if (no_pre_i) begin
              // First frame bit goes out immediately; keep the rest queued.
              r_state   <= S_FRAME;
              r_bit_cnt <= 6'd31;
              r_mdio    <= w_frame[31];
              r_tx      <= {w_frame[30:0], 1'b0};
            end else begin
              r_state   <= S_PRE;
              r_bit_cnt <= 6'd63;
              r_mdio    <= 1'b1;
              r_tx      <= w_frame;
            end
          end
        end

        S_PRE, S_FRAME, S_TA, S_DATA: begin
          if (!w_phase_end) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end else begin
            r_div_cnt <= '0;
            if (!r_mdc) begin
              // Rising MDC: capture the second TA bit and the data bits.
              r_mdc <= 1'b1;
              if (r_bit_cnt == 6'd16) begin
                r_ta_bit <= mdio_i;
              end
              if (r_bit_cnt < 6'd16) begin
                r_rx <= {r_rx[14:0], mdio_i};
              end
            end else begin
              // Falling MDC ends the bit.
              r_mdc <= 1'b0;
              if (r_bit_cnt == 6'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_oe    <= 1'b0;
                r_mdio  <= 1'b1;
                if (r_read) begin
                  r_rdata  <= r_rx;
                  r_rd_err <= r_ta_bit;
                end
              end else begin
                r_bit_cnt <= w_bit_next;
                if (w_bit_next >= 6'd32) begin
                  r_mdio <= 1'b1;
                end else begin
                  r_mdio <= r_tx[31];
                  r_tx   <= {r_tx[30:0], 1'b0};
                end
                // Reads release the line from the first TA bit onwards.
                r_oe <= ~r_read | (w_bit_next >= 6'd18);
                if (w_bit_next == 6'd31) begin
                  r_state <= S_FRAME;
                end else if (w_bit_next == 6'd17) begin
                  r_state <= S_TA;
                end else if (w_bit_next == 6'd15) begin
                  r_state <= S_DATA;
                end
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign rdata_o     = r_rdata;
  assign rd_err_o    = r_rd_err;
  assign mdc_o       = r_mdc;
  assign mdio_o      = r_mdio;
  assign mdio_oe_o   = r_oe;

endmodule

// File: tb/tb_iob_eth_mdio_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for iob_eth_mdio_ctrl. A frame-level model computes the expected
// outputs for every cycle from the bit timing rules (bit k spans cycles
// 1+2Hk..2H(k+1), MDC low for the first half), and one negedge process
// compares them against the DUT. Literal checks pin latency, frame contents
// and read results.
// ---------------------------------------------------------------------------
module tb_iob_eth_mdio_ctrl;

  logic        clk = 1'b0;
  logic        arst_n_i = 1'b1;
  logic        cke_i = 1'b1;
  logic [7:0]  clkdiv_i = 8'd2;
  logic        no_pre_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_read_i = 1'b0;
  logic        cmd_ready_o;
  logic [4:0]  phy_addr_i = 5'd0;
  logic [4:0]  reg_addr_i = 5'd0;
  logic [15:0] wdata_i = 16'd0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] rdata_o;
  logic        rd_err_o;
  logic        mdc_o;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        mdio_i = 1'b1;

  always #5 clk = ~clk;

  iob_eth_mdio_ctrl #(.DIV_W(8)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .clkdiv_i    (clkdiv_i),
    .no_pre_i    (no_pre_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_read_i  (cmd_read_i),
    .cmd_ready_o (cmd_ready_o),
    .phy_addr_i  (phy_addr_i),
    .reg_addr_i  (reg_addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .rd_err_o    (rd_err_o),
    .mdc_o       (mdc_o),
    .mdio_o      (mdio_o),
    .mdio_oe_o   (mdio_oe_o),
    .mdio_i      (mdio_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for the current cycle.
  logic        e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  logic        e_mdc = 1'b0, e_oe = 1'b0, e_mdio = 1'b1;
  logic [15:0] e_rdata = 16'd0;
  logic        e_rderr = 1'b0;
  int          cur_t = -1;

  // Model of the software-visible read result.
  logic [15:0] m_rdata = 16'd0;
  logic        m_rderr = 1'b0;

  // Observations gathered by the compare process.
  int          obs_done_t = -1;
  int          obs_oe_fall = -1;
  logic [63:0] obs_bits = '0;
  logic        prev_mdc = 1'b0, prev_oe = 1'b0;

  // Literal-check mailbox.
  string       pin_name = "";
  logic [63:0] pin_act = '0, pin_exp = '0;
  int          pin_seq = 0, pin_seen = 0;

  logic [22:0] act_v, exp_v;

  always @(negedge clk) begin
    act_v = {cmd_ready_o, busy_o, done_o, mdc_o, mdio_oe_o,
             e_oe ? mdio_o : 1'b0, rdata_o, rd_err_o};
    exp_v = {e_ready, e_busy, e_done, e_mdc, e_oe,
             e_oe ? e_mdio : 1'b0, e_rdata, e_rderr};
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL outputs t=%0d @%0t: got %h required %h (rdy,bsy,done,mdc,oe,mdio,rdata,err)",
                  cur_t, $time, act_v, exp_v);

    if (cur_t == 0) begin
      obs_done_t  = -1;
      obs_oe_fall = -1;
      obs_bits    = '0;
      prev_mdc    = 1'b0;
      prev_oe     = 1'b0;
    end else if (cur_t > 0) begin
      if (done_o && obs_done_t < 0) obs_done_t = cur_t;
      if (prev_oe && !mdio_oe_o && obs_oe_fall < 0) obs_oe_fall = cur_t;
      if (mdc_o && !prev_mdc) obs_bits = {obs_bits[62:0], mdio_o};
      prev_mdc = mdc_o;
      prev_oe  = mdio_oe_o;
    end

    if (pin_seq != pin_seen) begin
      pin_seen = pin_seq;
      n_checks++;
      if (pin_act === pin_exp) n_pass++;
      else $display("FAIL %s: got %h required %h", pin_name, pin_act, pin_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    e_mdc = 1'b0; e_oe = 1'b0; e_mdio = 1'b1;
    e_rdata = m_rdata; e_rderr = m_rderr;
    cur_t = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      tick();
    end
  endtask

  task automatic pin(input string name, input logic [63:0] act, input logic [63:0] exp);
    set_idle();
    pin_name = name;
    pin_act  = act;
    pin_exp  = exp;
    pin_seq++;
    tick();
  endtask

  // One command from acceptance (cycle 0) through DONE. Returns in the cycle
  // after DONE. stall_at freezes cke for 4 cycles at that cycle; abort_at
  // pulses reset at that cycle and returns early.
  task automatic run_txn(input bit rd, input logic [4:0] phy, input logic [4:0] rga,
                         input logic [15:0] wd, input bit nopre, input logic [7:0] cdiv,
                         input logic [15:0] resp, input bit ta, input bit hold,
                         input int stall_at, input int abort_at);
    int h, n, t, k, ph, f, stalls, last;
    logic [31:0] frame;
    h     = (cdiv < 8'd2) ? 2 : int'(cdiv);
    n     = nopre ? 32 : 64;
    frame = rd ? {2'b01, 2'b10, phy, rga, 18'h0} : {2'b01, 2'b01, phy, rga, 2'b10, wd};
    last  = 1 + 2 * h * n;
    $display("txn %s phy=%h reg=%h wdata=%h nopre=%0d clkdiv=%0d H=%0d done expected at %0d",
             rd ? "RD" : "WR", phy, rga, wd, nopre, cdiv, h, last);

    set_idle();
    cur_t       = 0;
    cmd_valid_i = 1'b1;
    cmd_read_i  = rd;
    phy_addr_i  = phy;
    reg_addr_i  = rga;
    wdata_i     = wd;
    no_pre_i    = nopre;
    clkdiv_i    = cdiv;
    tick();

    // Inputs are latched at acceptance; disturb them afterwards.
    cmd_read_i = ~rd;
    phy_addr_i = ~phy;
    reg_addr_i = ~rga;
    wdata_i    = ~wd;
    no_pre_i   = ~nopre;
    clkdiv_i   = cdiv + 8'd3;
    if (!hold) cmd_valid_i = 1'b0;

    t = 1;
    stalls = 4;
    while (t <= last) begin
      if (abort_at > 0 && t == abort_at) begin
        arst_n_i    = 1'b0;
        cmd_valid_i = 1'b0;
        mdio_i      = 1'b1;
        m_rdata     = 16'd0;
        m_rderr     = 1'b0;
        idle(2);
        arst_n_i = 1'b1;
        set_idle();
        return;
      end
      cur_t   = t;
      e_ready = 1'b0;
      e_busy  = 1'b1;
      if (t < last) begin
        k = (t - 1) / (2 * h);
        ph = (t - 1) % (2 * h);
        f = k - (n - 32);
        e_done = 1'b0;
        e_mdc  = (ph >= h);
        e_oe   = !rd || (f < 14);
        e_mdio = (f < 0) ? 1'b1 : frame[31 - f];
        if (rd && f == 15) mdio_i = ta;
        else if (rd && f >= 16) mdio_i = resp[31 - f];
        else mdio_i = 1'b1;
      end else begin
        e_done = 1'b1;
        e_mdc  = 1'b0;
        e_oe   = 1'b0;
        e_mdio = 1'b1;
        mdio_i = 1'b1;
        if (rd) begin
          m_rdata = resp;
          m_rderr = ta;
        end
        e_rdata = m_rdata;
        e_rderr = m_rderr;
      end
      if (t == stall_at && stalls > 0) begin
        cke_i = 1'b0;
        stalls--;
      end else begin
        cke_i = 1'b1;
        t++;
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    #2 arst_n_i = 1'b0;
    tick();
    tick();
    tick();
    arst_n_i = 1'b1;
    idle(100);
    pin("reset_mdio_o", {63'd0, mdio_o}, 64'd1);

    // Write with preamble, H=4.
    run_txn(1'b0, 5'h03, 5'h00, 16'h1200, 1'b0, 8'd4, 16'h0, 1'b0, 1'b0, 0, 0);
    pin("wr_pre_done_cycle", 64'(obs_done_t), 64'd513);
    pin("wr_pre_bits", obs_bits, 64'hFFFF_FFFF_5182_1200);
    pin("wr_pre_rdata", {48'd0, rdata_o}, 64'd0);

    // Read without preamble, H=2, PHY answers 0x796D.
    run_txn(1'b1, 5'h01, 5'h02, 16'h0, 1'b1, 8'd2, 16'h796D, 1'b0, 1'b0, 0, 0);
    pin("rd_done_cycle", 64'(obs_done_t), 64'd129);
    pin("rd_oe_fall_cycle", 64'(obs_oe_fall), 64'd57);
    pin("rd_rdata", {48'd0, rdata_o}, 64'h796D);
    pin("rd_err", {63'd0, rd_err_o}, 64'd0);

    // Read with no PHY response.
    run_txn(1'b1, 5'h1F, 5'h01, 16'h0, 1'b1, 8'd2, 16'hFFFF, 1'b1, 1'b0, 0, 0);
    pin("noresp_rdata", {48'd0, rdata_o}, 64'hFFFF);
    pin("noresp_err", {63'd0, rd_err_o}, 64'd1);

    // Divider boundaries.
    run_txn(1'b0, 5'h04, 5'h05, 16'hA5C3, 1'b1, 8'd0, 16'h0, 1'b0, 1'b0, 0, 0);
    pin("div0_done_cycle", 64'(obs_done_t), 64'd129);
    run_txn(1'b0, 5'h06, 5'h0A, 16'h3C5A, 1'b1, 8'd1, 16'h0, 1'b0, 1'b0, 0, 0);
    pin("div1_done_cycle", 64'(obs_done_t), 64'd129);
    run_txn(1'b1, 5'h11, 5'h1E, 16'h0, 1'b1, 8'd1, 16'h5A3C, 1'b0, 1'b0, 0, 0);

    // Clock-enable stall in the middle of a read, H=3.
    run_txn(1'b1, 5'h07, 5'h09, 16'h0, 1'b1, 8'd3, 16'hC0DE, 1'b0, 1'b0, 124, 0);
    pin("stall_rdata", {48'd0, rdata_o}, 64'hC0DE);

    // cmd_valid held high across back-to-back commands.
    run_txn(1'b0, 5'h02, 5'h03, 16'h0F0F, 1'b1, 8'd2, 16'h0, 1'b0, 1'b1, 0, 0);
    run_txn(1'b1, 5'h02, 5'h03, 16'h0, 1'b1, 8'd2, 16'h1234, 1'b0, 1'b0, 0, 0);
    idle(10);

    // Reset pulse mid-DATA, then a normal write with preamble.
    run_txn(1'b1, 5'h01, 5'h01, 16'h0, 1'b1, 8'd2, 16'hABCD, 1'b0, 1'b0, 0, 82);
    idle(3);
    run_txn(1'b0, 5'h03, 5'h04, 16'h8001, 1'b0, 8'd2, 16'h0, 1'b0, 1'b0, 0, 0);
    pin("after_reset_done_cycle", 64'(obs_done_t), 64'd257);
    pin("after_reset_rdata", {48'd0, rdata_o}, 64'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
